// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled in the system clock domain.
// SCLK/CS/MOSI are synchronized, edge-detected, and drive a two-state FSM
// with a one-deep tx holding register and an rx frame register.
module spi_slave #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [0:0]        state, state_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic [DATA_W-2:0] rx_shift, rx_shift_n;
  logic [DATA_W-1:0] rx_word;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              reload_pend, reload_pend_n;
  logic [DATA_W-1:0] hold_data, hold_data_n;
  logic              tx_ready_n;
  logic [DATA_W-1:0] rx_data_n;
  logic              rx_valid_n, busy_n, miso_n;
  logic              load, handshake;

  // Input synchronizers plus one extra stage for edge detection; reset to idle bus levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign rx_word   = {rx_shift, mosi_s};
  assign handshake = tx_valid_i & tx_ready_o;

  // Next-state and datapath logic; CS rise takes priority over SCLK edges.
  always_comb begin
    state_n       = state;
    tx_shift_n    = tx_shift;
    rx_shift_n    = rx_shift;
    cnt_n         = cnt;
    reload_pend_n = reload_pend;
    rx_data_n     = rx_data_o;
    rx_valid_n    = 1'b0;
    load          = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n       = SHIFT;
          load          = 1'b1;
          cnt_n         = '0;
          rx_shift_n    = '0;
          reload_pend_n = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_n       = IDLE;
          cnt_n         = '0;
          rx_shift_n    = '0;
          tx_shift_n    = '0;
          reload_pend_n = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_n = rx_word[DATA_W-2:0];
          if (cnt == CNT_W'(DATA_W - 1)) begin
            rx_data_n     = rx_word;
            rx_valid_n    = 1'b1;
            cnt_n         = '0;
            reload_pend_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (reload_pend) begin
            load          = 1'b1;
            reload_pend_n = 1'b0;
          end else begin
            tx_shift_n = {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Shifter always takes the pre-handshake holding contents.
    if (load) begin
      tx_shift_n = tx_ready_o ? '0 : hold_data;
    end

    hold_data_n = handshake ? tx_data_i : hold_data;
    if (handshake) begin
      tx_ready_n = 1'b0;
    end else if (load) begin
      tx_ready_n = 1'b1;
    end else begin
      tx_ready_n = tx_ready_o;
    end

    busy_n = (state_n == SHIFT);
    miso_n = (state_n == SHIFT) ? tx_shift_n[DATA_W-1] : 1'b0;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_shift    <= '0;
      rx_shift    <= '0;
      cnt         <= '0;
      reload_pend <= 1'b0;
      hold_data   <= '0;
      tx_ready_o  <= 1'b1;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      busy_o      <= 1'b0;
      spi_miso_o  <= 1'b0;
    end else begin
      state       <= state_n;
      tx_shift    <= tx_shift_n;
      rx_shift    <= rx_shift_n;
      cnt         <= cnt_n;
      reload_pend <= reload_pend_n;
      hold_data   <= hold_data_n;
      tx_ready_o  <= tx_ready_n;
      rx_data_o   <= rx_data_n;
      rx_valid_o  <= rx_valid_n;
      busy_o      <= busy_n;
      spi_miso_o  <= miso_n;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master drives frames,
// expected rx bytes are queued on drive and popped on each rx_valid_o pulse.
module tb_spi_slave;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned HALF   = 80;

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_clk_i, spi_cs_i, spi_mosi_i, spi_miso_o;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i, tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o, busy_o;

  int tests    = 0;
  int fails    = 0;
  int rx_count = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mi;

  spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk_i  (spi_clk_i),
    .spi_cs_i   (spi_cs_i),
    .spi_mosi_i (spi_mosi_i),
    .spi_miso_o (spi_miso_o),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_valid_o cycle pops one expected byte.
  always @(negedge clk) begin
    if (!rst && rx_valid_o) begin
      rx_count++;
      if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_valid_o), 32'h0);
      else                   check("rx_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
    end
  end

  // Shift n bits MSB first; MISO sampled just before each SCLK rise.
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi_o);
    mi_o = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi_i = mo[7-i];
      #HALF;
      mi_o = {mi_o[6:0], spi_miso_o};
      spi_clk_i = 1'b1;
      #HALF;
      spi_clk_i = 1'b0;
    end
  endtask

  task automatic load_tx(input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    while (!tx_ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("load_tx_ready", 32'(tx_ready_o), 32'h1);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    check("tx_ready_low", 32'(tx_ready_o), 32'h0);
  endtask

  task automatic cs_low();
    spi_cs_i = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    spi_cs_i = 1'b1;
    #HALF;
  endtask

  initial begin
    rst = 1'b1; spi_clk_i = 1'b0; spi_cs_i = 1'b1; spi_mosi_i = 1'b0;
    tx_data_i = '0; tx_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready_o), 32'h1);
    check("rst_rx_valid", 32'(rx_valid_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_miso", 32'(spi_miso_o), 32'h0);
    check("rst_rx_data", 32'(rx_data_o), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame with tx loaded.
    load_tx(8'hA5);
    cs_low();
    check("busy_in_frame", 32'(busy_o), 32'h1);
    check("ready_after_cs_fall", 32'(tx_ready_o), 32'h1);
    exp_q.push_back(8'h3C);
    spi_bits(8'h3C, 8, mi);
    check("miso_a5", 32'(mi), 32'hA5);
    cs_high();
    check("busy_idle", 32'(busy_o), 32'h0);
    check("miso_idle", 32'(spi_miso_o), 32'h0);
    check("rx_count_1", 32'(rx_count), 32'd1);

    // Frame with nothing loaded.
    exp_q.push_back(8'hFF);
    cs_low();
    spi_bits(8'hFF, 8, mi);
    check("miso_zero", 32'(mi), 32'h0);
    cs_high();
    check("rx_data_ff", 32'(rx_data_o), 32'hFF);

    // Two bytes under one CS, second tx loaded during byte 1.
    load_tx(8'h12);
    cs_low();
    load_tx(8'h34);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    spi_bits(8'h81, 8, mi);
    check("miso_b2b_0", 32'(mi), 32'h12);
    spi_bits(8'h7E, 8, mi);
    check("miso_b2b_1", 32'(mi), 32'h34);
    cs_high();
    check("rx_count_4", 32'(rx_count), 32'd4);

    // CS abort after 5 bits; holding register loaded mid-frame must survive.
    cs_low();
    load_tx(8'h99);
    spi_bits(8'hC3, 5, mi);
    cs_high();
    check("abort_busy", 32'(busy_o), 32'h0);
    check("abort_rx_data", 32'(rx_data_o), 32'h7E);
    check("abort_hold_kept", 32'(tx_ready_o), 32'h0);
    check("abort_rx_count", 32'(rx_count), 32'd4);
    exp_q.push_back(8'hC3);
    cs_low();
    spi_bits(8'hC3, 8, mi);
    check("miso_after_abort", 32'(mi), 32'h99);
    cs_high();
    check("rx_count_5", 32'(rx_count), 32'd5);

    // Reset mid-frame after 3 bits.
    cs_low();
    spi_bits(8'h5A, 3, mi);
    rst = 1'b1;
    spi_cs_i = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_busy", 32'(busy_o), 32'h0);
    check("mid_rst_miso", 32'(spi_miso_o), 32'h0);
    check("mid_rst_rx_valid", 32'(rx_valid_o), 32'h0);
    check("mid_rst_tx_ready", 32'(tx_ready_o), 32'h1);
    check("mid_rst_rx_data", 32'(rx_data_o), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back(8'h5A);
    cs_low();
    spi_bits(8'h5A, 8, mi);
    cs_high();
    check("rx_data_5a", 32'(rx_data_o), 32'h5A);
    check("rx_count_6", 32'(rx_count), 32'd6);

    // SCLK toggling with CS high is ignored.
    load_tx(8'h66);
    for (int i = 0; i < 8; i++) begin
      spi_clk_i = 1'b1;
      #HALF;
      check("idle_sclk_miso", 32'(spi_miso_o), 32'h0);
      spi_clk_i = 1'b0;
      #HALF;
    end
    check("idle_sclk_hold", 32'(tx_ready_o), 32'h0);
    check("idle_sclk_busy", 32'(busy_o), 32'h0);
    check("idle_sclk_rx_count", 32'(rx_count), 32'd6);
    exp_q.push_back(8'hAA);
    cs_low();
    spi_bits(8'hAA, 8, mi);
    check("miso_66", 32'(mi), 32'h66);
    cs_high();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    check("rx_count_final", 32'(rx_count), 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per SPI frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per SPI input (minimum 2).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic is in this domain.
REQ-004 SHALL have port rst, input, 1, meaning reset: asynchronous, active-high.
REQ-005 SHALL have port spi_clk_i, input, 1, meaning SCLK from the master (mode 0, CPOL=0, CPHA=0).
REQ-006 SHALL have port spi_cs_i, input, 1, meaning active-low chip select.
REQ-007 SHALL have port spi_mosi_i, input, 1, meaning master-out serial data, MSB first.
REQ-008 SHALL have port spi_miso_o, output, 1, meaning slave-out serial data, MSB first.
REQ-009 SHALL have port tx_data_i, input, DATA_W, meaning the byte to send in the next frame.
REQ-010 SHALL have port tx_valid_i, input, 1, meaning tx_data_i is valid.
REQ-011 SHALL have port tx_ready_o, output, 1, meaning the tx holding register is empty.
REQ-012 SHALL have port rx_data_o, output, DATA_W, meaning the last complete received frame.
REQ-013 SHALL have port rx_valid_o, output, 1, meaning a one-cycle pulse when rx_data_o updates.
REQ-014 SHALL have port busy_o, output, 1, meaning a frame is in progress (synchronized CS low).

Function
REQ-015 SHALL pass spi_clk_i, spi_cs_i and spi_mosi_i through SYNC_STAGES flops each, and SHALL register the last stage once more to detect edges; correct operation requires a clk frequency of at least 4x SCLK.
REQ-016 SHALL load the tx holding register on a clk edge where tx_valid_i and tx_ready_o are both high; tx_ready_o SHALL then go low until the holding register is consumed by the shifter.
REQ-017 SHALL implement FSM states IDLE and SHIFT: IDLE->SHIFT on a synchronized CS falling edge; SHIFT->IDLE on a synchronized CS rising edge.
REQ-018 On entering SHIFT, SHALL load the tx shifter from the holding register if it is full, marking the holding register empty; otherwise SHALL load all-zeros; bit counter SHALL be cleared to 0.
REQ-019 In SHIFT, on each synchronized SCLK rising edge, SHALL shift the synchronized MOSI value into the rx shifter LSB and increment the bit counter.
REQ-020 When the counter reaches DATA_W, SHALL copy the rx shifter to rx_data_o, pulse rx_valid_o for exactly one cycle SYNC_STAGES+1 clk cycles after the raw SCLK rising edge, and reset the counter to 0.
REQ-021 In SHIFT, on each synchronized SCLK falling edge, SHALL shift the tx shifter left by one; on the falling edge after the DATA_W-th rising edge, SHALL instead reload the shifter per REQ-018 to support back-to-back frames under one CS.
REQ-022 spi_miso_o SHALL equal tx shifter MSB in SHIFT and SHALL be 0 in IDLE; there is no tristate.
REQ-023 On a CS rise mid-frame (counter 1..DATA_W-1), SHALL discard the partial rx bits, SHALL NOT pulse rx_valid_o, SHALL drop the partial tx byte, and SHALL leave the holding register unchanged.
REQ-024 If a tx handshake and a shifter load occur in the same cycle, the shifter SHALL take the old holding contents (or zeros if empty), and the holding register SHALL take the new data and remain full.
REQ-025 SCLK edges seen while in IDLE SHALL be ignored.
REQ-026 busy_o SHALL be high exactly while the FSM is in SHIFT.

Reset
REQ-027 While rst is high: FSM=IDLE, all synchronizers reset to idle levels (CS=1, SCLK=0, MOSI=0), shifters/counter/rx_data_o=0, holding register empty, tx_ready_o=1, rx_valid_o=0, busy_o=0, spi_miso_o=0.
REQ-028 When rst asserts mid-frame, SHALL abort immediately with no rx_valid_o pulse; after release, SHALL wait for a fresh CS falling edge before shifting.

Verification
REQ-029 Load tx 0xA5, master sends 0x3C in one frame -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C with a single rx_valid_o pulse; tx_ready_o returns to 1 at the CS fall.
REQ-030 Frame with no tx loaded, master sends 0xFF -> MISO all 0, rx_data_o=0xFF.
REQ-031 Two bytes under one CS (tx 0x12, then load 0x34 during byte 1), MOSI 0x81,0x7E -> MISO 0x12 then 0x34; two rx_valid_o pulses with 0x81 then 0x7E.
REQ-032 CS rises after 5 SCLK edges -> no rx_valid_o, busy_o falls, rx_data_o keeps its previous value; the next full frame is received correctly.
REQ-033 Assert rst after 3 bits -> all outputs take their REQ-027 values; a following full frame 0x5A is received as 0x5A.
REQ-034 SCLK toggling with CS high -> no rx_valid_o, spi_miso_o=0, holding register untouched.
